interboard_link: RTL and testbench

//  Parametrised successor of the Bingo inter-board transceiver. It carries game messages {msg_type, number} between

---
 rtl/interboard_link_pkg.sv | 9 +
 rtl/interboard_link_if.sv | 11 +
 rtl/interboard_fifo.sv | 33 +++
 rtl/interboard_link.sv | 137 +++++++++++++
 tb/tb_interboard_link.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/interboard_link_pkg.sv
// interboard_link_pkg: shared state encodings, message constants and beat arithmetic for the inter-board link
package interboard_link_pkg;
    localparam logic [2:0] DEF_RST_TYPE = 3'b111;
    typedef enum logic [1:0] {T_IDLE, T_LOAD, T_REQ_HI, T_WAIT_ACK_LO} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_REL} rx_state_t;
    function automatic int beats_of(int bits, int w);
        return (bits + w - 1) / w;
    endfunction
endpackage

// File: rtl/interboard_link_if.sv
// interboard_link_if: board-to-board pin bundle; master is the transceiver side, slave is the peer side
interface interboard_link_if #(parameter int DATA_W = 6);
    logic              Request_out;
    logic              Ack_out;
    logic [DATA_W-1:0] inter_data_out;
    logic              Request_in;
    logic              Ack_in;
    logic [DATA_W-1:0] inter_data_in;
    modport master (output Request_out, Ack_out, inter_data_out, input Request_in, Ack_in, inter_data_in);
    modport slave (input Request_out, Ack_out, inter_data_out, output Request_in, Ack_in, inter_data_in);
endinterface

// File: rtl/interboard_fifo.sv
// interboard_fifo: synchronous FIFO with the head entry readable combinationally
module interboard_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign dout  = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/interboard_link.sv
// interboard_link: buffered four-phase Request/Ack transceiver carrying {msg_type, number} in DATA_W-bit beats
module interboard_link
    import interboard_link_pkg::*;
#(
    parameter int               DATA_W      = 6,
    parameter int               MSG_W       = 3,
    parameter int               NUM_W       = 5,
    parameter int               FIFO_DEPTH  = 4,
    parameter int               TIMEOUT_CYC = 1000000,
    parameter logic [MSG_W-1:0] RST_TYPE    = MSG_W'(DEF_RST_TYPE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ctrl_en,
    input  logic [MSG_W-1:0]   ctrl_msg_type,
    input  logic [NUM_W-1:0]   ctrl_number,
    output logic               inter_ready,
    output logic               tx_overflow,
    interboard_link_if.master  link,
    output logic               interboard_en,
    output logic [MSG_W-1:0]   interboard_msg_type,
    output logic [NUM_W-1:0]   interboard_number,
    output logic               interboard_rst,
    output logic               link_err
);
    localparam int W     = MSG_W + NUM_W;
    localparam int BEATS = beats_of(W, DATA_W);
    localparam int SW    = BEATS * DATA_W;
    localparam int BK_W  = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int TC_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TC_W-1:0] TC_LAST   = TC_W'(TIMEOUT_CYC - 1);
    localparam logic [BK_W-1:0] LAST_BEAT = BK_W'(BEATS - 1);
    // Request, Ack and data share one synchroniser chain so data stays aligned with its Request
    logic [DATA_W+1:0] sync1, sync2;
    logic              req_s, ack_s;
    logic [DATA_W-1:0] data_s;
    assign {req_s, ack_s, data_s} = sync2;
    always_ff @(posedge clk) begin
        if (rst) {sync2, sync1} <= '0;
        else {sync2, sync1} <= {sync1, link.Request_in, link.Ack_in, link.inter_data_in};
    end
    logic         push, pop, full, empty;
    logic [W-1:0] fifo_out;
    assign push        = ctrl_en && !full;
    assign inter_ready = !full;
    interboard_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk, .rst, .push, .pop, .din({ctrl_msg_type, ctrl_number}), .dout(fifo_out), .full, .empty
    );
    tx_state_t       tx_state, tx_next;
    logic [SW-1:0]   tx_sr;
    logic [BK_W-1:0] tx_beat;
    logic [TC_W-1:0] tx_cnt;
    logic            tx_abort, tx_to, tx_fail, tx_done;
    assign tx_to   = tx_cnt == TC_LAST;
    assign tx_fail = tx_to && (tx_state == T_REQ_HI ? !ack_s : tx_state == T_WAIT_ACK_LO && ack_s);
    assign tx_done = tx_state == T_WAIT_ACK_LO && !ack_s && !tx_abort && tx_beat == LAST_BEAT;
    assign link.Request_out    = tx_state == T_REQ_HI;
    assign link.inter_data_out = tx_sr[SW-1 -: DATA_W];
    always_comb begin
        tx_next = tx_state;
        pop = 1'b0;
        case (tx_state)
            T_IDLE: begin
                pop = !empty;
                tx_next = empty ? T_IDLE : T_LOAD;
            end
            T_LOAD: tx_next = T_REQ_HI;
            T_REQ_HI: tx_next = (ack_s || tx_to) ? T_WAIT_ACK_LO : T_REQ_HI;
            default: tx_next = !ack_s ? ((tx_abort || tx_beat == LAST_BEAT) ? T_IDLE : T_LOAD)
                                      : (tx_to ? T_IDLE : T_WAIT_ACK_LO);
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state    <= T_IDLE;
            tx_sr       <= '0;
            tx_beat     <= '0;
            tx_cnt      <= '0;
            tx_abort    <= 1'b0;
            tx_overflow <= 1'b0;
            link_err    <= 1'b0;
        end else begin
            tx_state    <= tx_next;
            tx_cnt      <= (tx_next != tx_state) ? '0 : tx_cnt + 1'b1;
            tx_overflow <= ctrl_en && full;
            if (pop) begin
                tx_sr    <= SW'(fifo_out);
                tx_beat  <= '0;
                tx_abort <= 1'b0;
            end else if (tx_state == T_WAIT_ACK_LO && tx_next == T_LOAD) begin
                tx_sr   <= tx_sr << DATA_W;
                tx_beat <= tx_beat + 1'b1;
            end
            if (tx_fail) begin
                tx_abort <= 1'b1;
                link_err <= 1'b1;
            end else if (tx_done) link_err <= 1'b0;
        end
    end
    rx_state_t       rx_state, rx_next;
    logic [SW-1:0]   rx_word;
    logic [BK_W-1:0] rx_beat;
    logic [TC_W-1:0] rx_cnt;
    logic            rx_last;
    assign rx_last = rx_state == R_REL && rx_beat == LAST_BEAT;
    assign link.Ack_out = rx_state == R_ACK;
    always_comb begin
        rx_next = rx_state == R_IDLE ? (req_s ? R_ACK : R_IDLE)
                : rx_state == R_ACK  ? (req_s ? R_ACK : R_REL) : R_IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state            <= R_IDLE;
            rx_word             <= '0;
            rx_beat             <= '0;
            rx_cnt              <= '0;
            interboard_en       <= 1'b0;
            interboard_rst      <= 1'b0;
            interboard_msg_type <= '0;
            interboard_number   <= '0;
        end else begin
            rx_state       <= rx_next;
            rx_cnt         <= (rx_state == R_IDLE && rx_beat != '0) ? rx_cnt + 1'b1 : '0;
            interboard_en  <= rx_last;
            interboard_rst <= rx_last && rx_word[W-1 -: MSG_W] == RST_TYPE;
            if (rx_state == R_IDLE && req_s) rx_word[SW - 1 - int'(rx_beat) * DATA_W -: DATA_W] <= data_s;
            if (rx_state == R_REL) begin
                rx_beat <= rx_last ? '0 : rx_beat + 1'b1;
                if (rx_last) {interboard_msg_type, interboard_number} <= rx_word[W-1:0];
            end else if (rx_state == R_IDLE && !req_s && rx_cnt == TC_LAST) rx_beat <= '0;
        end
    end
    if (SW > W) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^rx_word[SW-1:W];
    end
endmodule

// File: tb/tb_interboard_link.sv
// tb_interboard_link: directed checks on cross-wired link pairs with 6-bit (A->B) and 8-bit (C->D) beats
module tb_interboard_link;
    logic clk = 1'b0, rst = 1'b1, rst_a = 1'b0, block = 1'b0;
    always #5 clk = ~clk;
    int vectors = 0, errors = 0;
    logic       a_en = 1'b0, c_en = 1'b0;
    logic [2:0] a_type = '0, c_type = '0;
    logic [4:0] a_num = '0, c_num = '0;
    logic       a_ready, a_ovf, a_ien, a_irst, a_err, b_ready, b_ovf, b_ien, b_irst, b_err;
    logic       c_ready, c_ovf, c_ien, c_irst, c_err, d_ready, d_ovf, d_ien, d_irst, d_err;
    logic [2:0] a_itype, b_itype, c_itype, d_itype;
    logic [4:0] a_inum, b_inum, c_inum, d_inum;
    interboard_link_if #(.DATA_W(6)) la(), lb();
    interboard_link_if #(.DATA_W(8)) lc(), ld();
    assign lb.Request_in = la.Request_out;
    assign lb.Ack_in = la.Ack_out;
    assign lb.inter_data_in = la.inter_data_out;
    assign la.Request_in = lb.Request_out;
    assign la.Ack_in = lb.Ack_out && !block;
    assign la.inter_data_in = lb.inter_data_out;
    assign ld.Request_in = lc.Request_out;
    assign ld.Ack_in = lc.Ack_out;
    assign ld.inter_data_in = lc.inter_data_out;
    assign lc.Request_in = ld.Request_out;
    assign lc.Ack_in = ld.Ack_out;
    assign lc.inter_data_in = ld.inter_data_out;
    interboard_link #(.TIMEOUT_CYC(64)) u_a (
        .clk, .rst(rst || rst_a), .ctrl_en(a_en), .ctrl_msg_type(a_type), .ctrl_number(a_num),
        .inter_ready(a_ready), .tx_overflow(a_ovf), .link(la), .interboard_en(a_ien),
        .interboard_msg_type(a_itype), .interboard_number(a_inum), .interboard_rst(a_irst), .link_err(a_err));
    interboard_link #(.TIMEOUT_CYC(64)) u_b (
        .clk, .rst, .ctrl_en(1'b0), .ctrl_msg_type(3'd0), .ctrl_number(5'd0),
        .inter_ready(b_ready), .tx_overflow(b_ovf), .link(lb), .interboard_en(b_ien),
        .interboard_msg_type(b_itype), .interboard_number(b_inum), .interboard_rst(b_irst), .link_err(b_err));
    interboard_link #(.DATA_W(8), .TIMEOUT_CYC(64)) u_c (
        .clk, .rst, .ctrl_en(c_en), .ctrl_msg_type(c_type), .ctrl_number(c_num),
        .inter_ready(c_ready), .tx_overflow(c_ovf), .link(lc), .interboard_en(c_ien),
        .interboard_msg_type(c_itype), .interboard_number(c_inum), .interboard_rst(c_irst), .link_err(c_err));
    interboard_link #(.DATA_W(8), .TIMEOUT_CYC(64)) u_d (
        .clk, .rst, .ctrl_en(1'b0), .ctrl_msg_type(3'd0), .ctrl_number(5'd0),
        .inter_ready(d_ready), .tx_overflow(d_ovf), .link(ld), .interboard_en(d_ien),
        .interboard_msg_type(d_itype), .interboard_number(d_inum), .interboard_rst(d_irst), .link_err(d_err));
    logic [7:0] b_q[$], d_q[$];
    int   a_req_rises = 0, rst_both = 0, rst_alone = 0;
    logic a_req_d = 1'b0;
    always @(negedge clk) begin
        if (la.Request_out === 1'b1 && a_req_d === 1'b0) a_req_rises++;
        a_req_d = la.Request_out;
        if (b_ien === 1'b1) b_q.push_back({b_itype, b_inum});
        if (d_ien === 1'b1) d_q.push_back({d_itype, d_inum});
        if (b_irst === 1'b1 && b_ien === 1'b1) rst_both++;
        if (b_irst === 1'b1 && b_ien !== 1'b1) rst_alone++;
    end
    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic send_a(logic [2:0] t, logic [4:0] n);
        a_en = 1'b1;
        a_type = t;
        a_num = n;
        @(negedge clk);
        a_en = 1'b0;
    endtask
    task automatic wait_b(int n);
        for (int i = 0; i < 1000 && b_q.size() < n; i++) @(negedge clk);
        check("b_msg_count", b_q.size(), n);
    endtask
    task automatic wait_a_req();
        for (int i = 0; i < 20 && la.Request_out !== 1'b1; i++) @(negedge clk);
        check("a_req_seen", la.Request_out, 1'b1);
    endtask
    initial begin
        int n, hi;
        repeat (3) @(negedge clk);
        check("rst_ready", a_ready, 1'b1);
        check("rst_req", la.Request_out, 1'b0);
        check("rst_ack", lb.Ack_out, 1'b0);
        check("rst_data", la.inter_data_out, 6'h00);
        check("rst_err", a_err, 1'b0);
        check("rst_ovf", a_ovf, 1'b0);
        check("rst_en", b_ien, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        send_a(3'd2, 5'd17);
        @(negedge clk);
        check("t1_data_t2", la.inter_data_out, 6'h01);
        check("t1_req_t2", la.Request_out, 1'b0);
        @(negedge clk);
        check("t1_req_t3", la.Request_out, 1'b1);
        wait_b(1);
        check("t1_msg", b_q[0], {3'd2, 5'd17});
        check("t1_held_type", b_itype, 3'd2);
        check("t1_held_num", b_inum, 5'd17);
        repeat (40) @(negedge clk);
        check("t1_req_pulses", a_req_rises, 2);
        check("t1_err", a_err, 1'b0);
        for (int i = 0; i < 6; i++) begin
            a_en = 1'b1;
            a_type = 3'(i);
            a_num = 5'(10 + i);
            if (i == 4) check("t2_ready_3", a_ready, 1'b1);
            if (i == 5) check("t2_ready_full", a_ready, 1'b0);
            @(negedge clk);
        end
        a_en = 1'b0;
        check("t2_ovf_pulse", a_ovf, 1'b1);
        @(negedge clk);
        check("t2_ovf_end", a_ovf, 1'b0);
        wait_b(6);
        for (int i = 1; i < 6; i++) check("t2_order", b_q[i], {3'(i - 1), 5'(9 + i)});
        repeat (40) @(negedge clk);
        check("t2_no_sixth", b_q.size(), 6);
        check("t2_ready_back", a_ready, 1'b1);
        block = 1'b1;
        n = b_q.size();
        send_a(3'd5, 5'd3);
        wait_a_req();
        hi = 0;
        for (int i = 0; i < 200 && la.Request_out === 1'b1; i++) begin
            hi++;
            @(negedge clk);
        end
        check("t3_req_hi_len", hi, 64);
        check("t3_err_set", a_err, 1'b1);
        repeat (100) @(negedge clk);
        check("t3_err_sticky", a_err, 1'b1);
        check("t3_no_rx", b_q.size(), n);
        block = 1'b0;
        send_a(3'd6, 5'd9);
        wait_b(n + 1);
        check("t3_resend", b_q[n], {3'd6, 5'd9});
        repeat (20) @(negedge clk);
        check("t3_err_clear", a_err, 1'b0);
        check("t4_no_rst_yet", rst_both, 0);
        n = b_q.size();
        send_a(3'd7, 5'd0);
        wait_b(n + 1);
        check("t4_msg", b_q[n], {3'd7, 5'd0});
        repeat (20) @(negedge clk);
        check("t4_rst_with_en", rst_both, 1);
        check("t4_rst_alone", rst_alone, 0);
        n = b_q.size();
        send_a(3'd1, 5'd1);
        wait_a_req();
        rst_a = 1'b1;
        @(negedge clk);
        check("t5_req", la.Request_out, 1'b0);
        check("t5_data", la.inter_data_out, 6'h00);
        check("t5_ack", la.Ack_out, 1'b0);
        check("t5_ready", a_ready, 1'b1);
        check("t5_ovf", a_ovf, 1'b0);
        check("t5_en", a_ien, 1'b0);
        check("t5_rx_fields", {a_itype, a_inum, a_irst}, 9'h0);
        rst_a = 1'b0;
        repeat (150) @(negedge clk);
        check("t5_no_partial", b_q.size(), n);
        send_a(3'd3, 5'd21);
        wait_b(n + 1);
        check("t5_after_expiry", b_q[n], {3'd3, 5'd21});
        c_en = 1'b1;
        c_type = 3'd5;
        c_num = 5'd31;
        @(negedge clk);
        c_en = 1'b0;
        @(negedge clk);
        check("t6_data", lc.inter_data_out, 8'hBF);
        @(negedge clk);
        check("t6_req", lc.Request_out, 1'b1);
        for (int i = 0; i < 200 && d_q.size() < 1; i++) @(negedge clk);
        repeat (30) @(negedge clk);
        check("t6_count", d_q.size(), 1);
        check("t6_msg", {d_itype, d_inum}, {3'd5, 5'd31});
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
